// File: rtl/fm_stream_reader_if.sv
// fm_stream_reader_if: beat stream from the plane reader to the conv datapath.
// master drives valid/data/last, slave returns ready.
interface fm_stream_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PARA_Y     = 3
);
    logic                         out_valid;
    logic                         out_ready;
    logic [PARA_Y*DATA_WIDTH-1:0] out_data;
    logic                         out_last;

    modport master (
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/fm_stream_reader.sv
// fm_stream_reader: float16 feature-map plane read sequencer, 2-deep beat buffer.
// Optional ZERO_PAD_EN adds pad_en for a zero-bordered (fm_size+2)^2 walk.
module fm_stream_reader #(
    parameter int DATA_WIDTH    = 16,
    parameter int PARA_Y        = 3,
    parameter int ADDR_WIDTH    = 16,
    parameter int FM_SIZE_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [FM_SIZE_WIDTH-1:0]     fm_size,
`ifdef ZERO_PAD_EN
    input  logic                         pad_en,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [ADDR_WIDTH-1:0]        rd_sub_addr,
    input  logic [PARA_Y*DATA_WIDTH-1:0] rd_dout,
    fm_stream_reader_if.master           strm
);
    localparam int CW = FM_SIZE_WIDTH + 2;
    localparam int BW = PARA_Y * DATA_WIDTH;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);
    localparam logic [CW-1:0] STEP = CW'(PARA_Y);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t                state;
    logic [CW-1:0]         sz;
    logic [CW-1:0]         row;
    logic [CW-1:0]         col;
    logic [ADDR_WIDTH-1:0] row_base;
    logic                  pad_q;

    logic                  pf_valid;
    logic                  pf_zero;
    logic                  pf_shift;
    logic                  pf_last;
    logic [CW-1:0]         pf_col;

    logic [BW-1:0]         buf_d [2];
    logic                  buf_l [2];
    logic                  wp;
    logic                  rp;
    logic [1:0]            cnt;

    logic [CW-1:0]         n;
    logic [CW-1:0]         ocol;
    logic [CW-1:0]         lc;
    logic                  lane_ok;
    logic                  border;
    logic                  row_end;
    logic                  last_beat;
    logic                  pop;
    logic                  credit;
    logic [1:0]            occ;
    logic [BW-1:0]         src;
    logic [BW-1:0]         beat;

`ifdef ZERO_PAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pad_q <= 1'b0;
        else if (state == IDLE && start)
            pad_q <= pad_en;
    end
`else
    assign pad_q = 1'b0;
`endif

    assign n         = pad_q ? sz + TWO : sz;
    assign border    = pad_q && (row == '0 || row == n - ONE);
    assign ocol      = (pad_q && col != '0) ? col - ONE : col;
    assign row_end   = (col + STEP) >= n;
    assign last_beat = row_end && (row == n - ONE);
    assign pop       = strm.out_valid && strm.out_ready;
    // occupancy after this edge: held entries plus the landing read, minus pop
    assign occ       = cnt + {1'b0, pf_valid} - {1'b0, pop};
    assign credit    = occ < 2'd2;

    // pad column 0 shifts RAM lanes up by one so lane 0 is the left border
    assign src = pf_shift ? {rd_dout[BW-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}}
                          : rd_dout;

    always_comb begin
        beat    = '0;
        lc      = '0;
        lane_ok = 1'b0;
        for (int k = 0; k < PARA_Y; k++) begin
            lc      = pf_col + CW'(k);
            lane_ok = pad_q ? (lc != '0 && lc <= sz) : (lc < sz);
            if (lane_ok && !pf_zero)
                beat[k*DATA_WIDTH +: DATA_WIDTH] = src[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            buf_d[0] <= '0;
            buf_d[1] <= '0;
            buf_l[0] <= 1'b0;
            buf_l[1] <= 1'b0;
        end else begin
            if (pf_valid) begin
                buf_d[wp] <= beat;
                buf_l[wp] <= pf_last;
                wp        <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            cnt <= occ;
        end
    end

    assign strm.out_valid = cnt != 2'd0;
    assign strm.out_data  = buf_d[rp];
    assign strm.out_last  = strm.out_valid && buf_l[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rd_sub_addr <= '0;
            sz          <= '0;
            row         <= '0;
            col         <= '0;
            row_base    <= '0;
            pf_valid    <= 1'b0;
            pf_zero     <= 1'b0;
            pf_shift    <= 1'b0;
            pf_last     <= 1'b0;
            pf_col      <= '0;
        end else begin
            pf_valid <= 1'b0;
            rd_en    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        sz       <= CW'(fm_size);
                        rd_addr  <= base_addr;
                        row      <= '0;
                        col      <= '0;
                        row_base <= '0;
                        state    <= (fm_size == '0) ? FIN : READ;
                    end
                end
                READ: begin
                    if (credit) begin
                        pf_valid    <= 1'b1;
                        rd_en       <= !border;
                        rd_sub_addr <= row_base + ADDR_WIDTH'(ocol);
                        pf_zero     <= border;
                        pf_shift    <= pad_q && col == '0;
                        pf_col      <= col;
                        pf_last     <= last_beat;
                        if (row_end) begin
                            col <= '0;
                            row <= row + ONE;
                            if (!border)
                                row_base <= row_base + ADDR_WIDTH'(sz);
                            if (last_beat)
                                state <= DRAIN;
                        end else begin
                            col <= col + STEP;
                        end
                    end
                end
                DRAIN: begin
                    if (occ == 2'd0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    // entered with done=0 only on an empty plane: pulse it here
                    done <= !done;
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fm_stream_reader.sv
// tb_fm_stream_reader: table-driven and random plane walks against a
// geometric reference model of the feature-map reader.
module tb_fm_stream_reader;
    localparam int DW = 16;
    localparam int PY = 3;
    localparam int AW = 16;
    localparam int FW = 8;
    localparam int BW = PY * DW;

    typedef struct packed {
        logic [BW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct {
        int sz;
        int pad;
        int mode;
        int restart;
        int beats;
        int reads;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [FW-1:0] fm_size = '0;
`ifdef ZERO_PAD_EN
    logic          pad_en = 1'b0;
`endif
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_sub_addr;
    logic [BW-1:0] rd_dout;

    fm_stream_reader_if #(.DATA_WIDTH(DW), .PARA_Y(PY)) strm ();

    fm_stream_reader #(
        .DATA_WIDTH(DW), .PARA_Y(PY), .ADDR_WIDTH(AW), .FM_SIZE_WIDTH(FW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .fm_size(fm_size),
`ifdef ZERO_PAD_EN
        .pad_en(pad_en),
`endif
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_sub_addr(rd_sub_addr),
        .rd_dout(rd_dout),
        .strm(strm)
    );

    always #5 clk = ~clk;

    // RAM: element i holds i+1; data is valid in the cycle rd_en is high
    always_comb begin
        for (int k = 0; k < PY; k++)
            rd_dout[k*DW +: DW] = rd_en ? DW'(32'(rd_sub_addr) + k + 1) : 16'hDEAD;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int ph = 0;
    int rmode = 0;
    logic [AW-1:0] cur_base = '0;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    rd_q[$];
    int    exp_rd[$];
    int    done_cyc[$];
    int    xfer_cyc = -1;
    int    n_rd = 0;
    int    addr_err = 0;
    int    stall_err = 0;
    int    credit_err = 0;
    logic  pv_stall = 1'b0;
    beat_t pv_beat = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                rd_q.push_back(int'(rd_sub_addr));
                n_rd++;
                if (rd_addr !== cur_base) addr_err++;
            end
            if (n_rd - got_q.size() > 2) credit_err++;
            if (pv_stall && (!strm.out_valid || strm.out_data !== pv_beat.d ||
                             strm.out_last !== pv_beat.l))
                stall_err++;
            pv_stall  = strm.out_valid && !strm.out_ready;
            pv_beat.d = strm.out_data;
            pv_beat.l = strm.out_last;
            if (strm.out_valid && strm.out_ready) begin
                got_q.push_back(pv_beat);
                xfer_cyc = cyc;
            end
            if (done) done_cyc.push_back(cyc);
        end else begin
            pv_stall = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, g, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ph++;
        case (rmode)
            0:       strm.out_ready = 1'b1;
            1:       strm.out_ready = (ph % 3 == 0);
            default: strm.out_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    // expected beats and RAM offsets straight from the plane geometry
    task automatic build_exp(input int sz, input int pad);
        int n;
        int dr;
        int oc;
        beat_t b;
        exp_q.delete();
        exp_rd.delete();
        if (sz == 0) return;
        n = (pad != 0) ? sz + 2 : sz;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c += PY) begin
                dr = (pad != 0) ? r - 1 : r;
                b  = '0;
                for (int k = 0; k < PY; k++) begin
                    oc = (pad != 0) ? c + k - 1 : c + k;
                    if (dr >= 0 && dr < sz && oc >= 0 && oc < sz)
                        b.d[k*DW +: DW] = DW'(dr * sz + oc + 1);
                end
                b.l = (r == n - 1) && (c + PY >= n);
                exp_q.push_back(b);
                if (dr >= 0 && dr < sz)
                    exp_rd.push_back(dr * sz + ((pad != 0 && c > 0) ? c - 1 : c));
            end
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        rd_q.delete();
        done_cyc.delete();
        n_rd = 0;
        addr_err = 0;
        stall_err = 0;
        credit_err = 0;
        xfer_cyc = -1;
    endtask

    task automatic run_walk(input int sz, input int pad, input int mode,
                            input int restart, input logic [AW-1:0] base);
        int bound;
        int t;
        int t_start;
        int exp_done;
        build_exp(sz, pad);
        clear_mon();
        rmode     = mode;
        cur_base  = base;
        base_addr = base;
        fm_size   = FW'(sz);
`ifdef ZERO_PAD_EN
        pad_en    = (pad != 0);
`endif
        start     = 1'b1;
        t_start   = cyc;
        tick();
        start     = 1'b0;
        fm_size   = FW'(sz + 5);
        base_addr = ~base;
        bound = 40 + 8 * (sz + 2) * (sz + 2);
        t = 0;
        while (done_cyc.size() == 0 && t < bound) begin
            if (t == restart) begin
                start   = 1'b1;
                fm_size = 8'd2;
            end
            tick();
            start = 1'b0;
            t++;
        end
        chk("walk_timeout", 64'(t >= bound), 64'(0));
        repeat (4) tick();
        chk("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("beat_data", 64'(got_q[i].d), 64'(exp_q[i].d));
            chk("beat_last", 64'(got_q[i].l), 64'(exp_q[i].l));
        end
        chk("read_count", 64'(rd_q.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
            chk("read_addr", 64'(rd_q[i]), 64'(exp_rd[i]));
        chk("rd_addr_base", 64'(addr_err), 64'(0));
        chk("stall_stable", 64'(stall_err), 64'(0));
        chk("credit_limit", 64'(credit_err), 64'(0));
        chk("done_count", 64'(done_cyc.size()), 64'(1));
        exp_done = (sz == 0) ? t_start + 2 : xfer_cyc + 1;
        if (done_cyc.size() > 0)
            chk("done_timing", 64'(done_cyc[0]), 64'(exp_done));
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    vec_t tbl[$];
    int   t1_addr[8];
    int   t;

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        strm.out_ready = 1'b0;
        #12;
        chk("reset_ctrl", 64'({busy, done, rd_en, strm.out_valid, strm.out_last}), 64'(0));
        chk("reset_addr", 64'({rd_addr, rd_sub_addr}), 64'(0));
        chk("reset_data", 64'(strm.out_data), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        tbl.push_back('{4, 0, 0, -1, 8, 8});
        tbl.push_back('{4, 0, 1, -1, 8, 8});
        tbl.push_back('{0, 0, 0, -1, 0, 0});
        tbl.push_back('{4, 0, 0, 2, 8, 8});
        tbl.push_back('{1, 0, 0, -1, 1, 1});
        tbl.push_back('{3, 0, 1, -1, 3, 3});
        tbl.push_back('{5, 0, 2, -1, 10, 10});
        tbl.push_back('{7, 0, 0, -1, 21, 21});
`ifdef ZERO_PAD_EN
        tbl.push_back('{2, 1, 0, -1, 8, 4});
        tbl.push_back('{3, 1, 1, -1, 10, 6});
`endif
        foreach (tbl[i]) begin
            run_walk(tbl[i].sz, tbl[i].pad, tbl[i].mode, tbl[i].restart, 16'h0000);
            chk("tbl_beats", 64'(got_q.size()), 64'(tbl[i].beats));
            chk("tbl_reads", 64'(n_rd), 64'(tbl[i].reads));
        end

        // fm_size=4 walk: exact addresses and lane values
        t1_addr = '{0, 3, 4, 7, 8, 11, 12, 15};
        run_walk(4, 0, 0, -1, 16'h0000);
        chk("t1_nbeats", 64'(got_q.size()), 64'(8));
        chk("t1_nreads", 64'(rd_q.size()), 64'(8));
        if (got_q.size() == 8 && rd_q.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk("t1_addr", 64'(rd_q[i]), 64'(t1_addr[i]));
            chk("t1_beat0", 64'(got_q[0].d), 64'({16'd3, 16'd2, 16'd1}));
            chk("t1_beat1", 64'(got_q[1].d), 64'({16'd0, 16'd0, 16'd4}));
            chk("t1_beat7", 64'(got_q[7].d), 64'({16'd0, 16'd0, 16'd16}));
            chk("t1_last7", 64'(got_q[7].l), 64'(1));
            chk("t1_last6", 64'(got_q[6].l), 64'(0));
        end

        // reset asserted while beat 3 is in flight
        clear_mon();
        rmode = 0;
        cur_base = '0;
        base_addr = '0;
        fm_size = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (got_q.size() < 3 && t < 50) begin
            tick();
            t++;
        end
        chk("rst_reach_beat3", 64'(t >= 50), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", 64'({busy, done, rd_en, strm.out_valid, strm.out_last}), 64'(0));
        chk("rst_async_addr", 64'({rd_addr, rd_sub_addr}), 64'(0));
        chk("rst_async_data", 64'(strm.out_data), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        clear_mon();
        repeat (6) tick();
        chk("rst_no_done", 64'(done_cyc.size()), 64'(0));
        chk("rst_no_beats", 64'(got_q.size()), 64'(0));
        chk("rst_no_reads", 64'(n_rd), 64'(0));
        run_walk(4, 0, 0, -1, 16'h0000);

`ifdef ZERO_PAD_EN
        run_walk(2, 1, 0, -1, 16'h0000);
        chk("pad_nbeats", 64'(got_q.size()), 64'(8));
        chk("pad_nreads", 64'(n_rd), 64'(4));
        if (got_q.size() == 8) begin
            chk("pad_row0", 64'(got_q[0].d | got_q[1].d), 64'(0));
            chk("pad_r1b0", 64'(got_q[2].d), 64'({16'd2, 16'd1, 16'd0}));
            chk("pad_r1b1", 64'(got_q[3].d), 64'(0));
            chk("pad_r2b0", 64'(got_q[4].d), 64'({16'd4, 16'd3, 16'd0}));
            chk("pad_row3", 64'(got_q[6].d | got_q[7].d), 64'(0));
            chk("pad_last", 64'(got_q[7].l), 64'(1));
        end
`endif

        for (int i = 0; i < 20; i++) begin
            int sz;
            int pad;
            sz  = $urandom_range(0, 10);
            pad = 0;
`ifdef ZERO_PAD_EN
            pad = $urandom_range(0, 1);
`endif
            run_walk(sz, pad, 2, -1, AW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
